// File: rtl/steer_pkg.sv
// Shared types for the steering sequencer: command codes, FSM states,
// and the steering decision map.
package steer_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    FWD   = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ISSUE,
    EXEC
  } state_e;

  function automatic cmd_e decide(
    input logic l,
    input logic r,
    input logic w
  );
    if (w)           return FWD;
    else if (l && !r) return LEFT;
    else if (r && !l) return RIGHT;
    else             return STOP;
  endfunction

endpackage

// File: rtl/steer_sequencer_debounce.sv
// Sensor debounce: holds the last sensor vector and counts identical samples.
// Optional STEER_SAFE_ABORT_EN exposes the held-vs-live difference.
module steer_debounce #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] sensor,
  input  logic       start,
  input  logic       clear,
`ifdef STEER_SAFE_ABORT_EN
  output logic       diff,
`endif
  output logic       stable
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [4:0]    s_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt;
  logic          active;

  assign active = start || (cnt != '0);

  always_comb begin
    nxt = CW'(1);
    if (!start && sensor == s_q) nxt = cnt + CW'(1);
  end

  // Fires on the edge whose count would reach the threshold.
  assign stable = !clear && active && (nxt == CW'(SETTLE_CYCLES));

`ifdef STEER_SAFE_ABORT_EN
  assign diff = sensor != s_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= '0;
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active) begin
      if (start || sensor != s_q) s_q <= sensor;
      cnt <= stable ? '0 : nxt;
    end
  end

endmodule

// File: rtl/steer_sequencer.sv
// Steering sequencer: debounce, sample decision, issue, execute, re-arm.
// Optional abort of FWD on sensor change: define STEER_SAFE_ABORT_EN.
module steer_sequencer
  import steer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int TURN_CYCLES   = 8,
  parameter int WALK_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [4:0]       sensor,
  input  logic             steer_left,
  input  logic             steer_right,
  input  logic             steer_walk,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd,
  output logic             busy,
`ifdef STEER_SAFE_ABORT_EN
  output logic             abort_pulse,
`endif
  output logic [CNT_W-1:0] walk_count
);

  localparam int DMAX = (TURN_CYCLES > WALK_CYCLES) ? TURN_CYCLES : WALK_CYCLES;
  localparam int DW   = $clog2(DMAX + 1);

  state_e        state;
  cmd_e          cmd_q;
  cmd_e          dec;
  logic [DW-1:0] dur;
  logic          start;
  logic          clear;
  logic          stable;
  logic          abort;
  logic          done;

  assign dec = decide(steer_left, steer_right, steer_walk);
  assign cmd = cmd_q;

`ifdef STEER_SAFE_ABORT_EN
  logic diff;
  assign abort = (state == EXEC) && (cmd_q == FWD) && diff;
`else
  assign abort = 1'b0;
`endif

  assign done  = (state == EXEC) && (dur == DW'(1)) && !abort;
  assign start = ((state == IDLE) && enable) || (done && enable) || abort;
  assign clear = (state == SETTLE) && !enable;

  steer_debounce #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_deb (
    .clk    (clk),
    .reset_n(reset_n),
    .sensor (sensor),
    .start  (start),
    .clear  (clear),
`ifdef STEER_SAFE_ABORT_EN
    .diff   (diff),
`endif
    .stable (stable)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd_q      <= STOP;
      cmd_valid  <= 1'b0;
      busy       <= 1'b0;
      dur        <= '0;
      walk_count <= '0;
`ifdef STEER_SAFE_ABORT_EN
      abort_pulse <= 1'b0;
`endif
    end else begin
`ifdef STEER_SAFE_ABORT_EN
      abort_pulse <= abort;
`endif
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= SETTLE;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (cmd_q == STOP) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= EXEC;
              dur   <= (cmd_q == FWD) ? DW'(WALK_CYCLES) : DW'(TURN_CYCLES);
            end
          end
        end
        EXEC: begin
          if (abort) begin
            state <= SETTLE;
            dur   <= '0;
          end else if (done) begin
            dur <= '0;
            if (cmd_q == FWD && walk_count != '1)
              walk_count <= walk_count + 1'b1;
            if (enable) begin
              state <= SETTLE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dur <= dur - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // A settled vector overrides the case outcome and samples the decision.
      if (stable) begin
        state     <= ISSUE;
        cmd_q     <= dec;
        cmd_valid <= 1'b1;
        busy      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_steer_sequencer.sv
// Bench for steer_sequencer: vector table plus scoreboard of issued commands.
// Build with or without STEER_SAFE_ABORT_EN.
module tb_steer_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [4:0] sensor;
  logic       steer_left;
  logic       steer_right;
  logic       steer_walk;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       busy;
  logic [1:0] walk_count;
`ifdef STEER_SAFE_ABORT_EN
  logic       abort_pulse;
`endif

  int checks = 0;
  int errors = 0;
  int hs = 0;
  int wc_m = 0;
  logic [1:0] expq[$];
  logic [1:0] e_mon;

  typedef struct {
    logic [4:0] s;
    logic [1:0] c;
    int         d;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  // Stand-in for the steering decoder
  assign steer_walk  = &sensor;
  assign steer_left  = sensor[4];
  assign steer_right = sensor[1];

  steer_sequencer #(.CNT_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .sensor     (sensor),
    .steer_left (steer_left),
    .steer_right(steer_right),
    .steer_walk (steer_walk),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .busy       (busy),
`ifdef STEER_SAFE_ABORT_EN
    .abort_pulse(abort_pulse),
`endif
    .walk_count (walk_count)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      hs++;
      if (expq.size() == 0) begin
        chk("unexpected_handshake", 1, 0);
      end else begin
        e_mon = expq.pop_front();
        chk("hs_cmd", int'(cmd), int'(e_mon));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    do begin
      step();
      n++;
    end while (cmd_valid !== 1'b1 && n < 50);
    chk(nm, n, 4);
  endtask

  task automatic finish_cmd(input string nm, input int exp_dur);
    int k = 0;
    step();
    enable = 1'b0;
    chk({nm, "_valid_drop"}, int'(cmd_valid), 0);
    while (busy === 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk({nm, "_dur"}, k, exp_dur);
  endtask

  task automatic run_vec(input logic [4:0] s, input logic [1:0] c,
                         input int d, input string nm);
    sensor    = s;
    enable    = 1'b1;
    cmd_ready = 1'b1;
    expq.push_back(c);
    wait_valid({nm, "_lat"});
    finish_cmd(nm, d);
    if (c == 2'b01 && wc_m < 3) wc_m++;
    chk({nm, "_walk_count"}, int'(walk_count), wc_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int h0;
    logic ok;
    tbl[0] = '{5'b01110, 2'b11, 8};
    tbl[1] = '{5'b11111, 2'b01, 16};
    tbl[2] = '{5'b10000, 2'b10, 8};
    tbl[3] = '{5'b01000, 2'b00, 0};
    tbl[4] = '{5'b11010, 2'b00, 0};
    tbl[5] = '{5'b11111, 2'b01, 16};

    reset_n   = 1'b0;
    enable    = 1'b1;
    sensor    = 5'b00000;
    cmd_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_walk_count", int'(walk_count), 0);

    reset_n = 1'b1;
    expq.push_back(2'b00);
    wait_valid("rst_lat");
    chk("rst_cmd_stop", int'(cmd), 0);
    step();
    chk("rst_back_idle", int'(busy), 0);
    step();
    chk("rst_resettle", int'(busy), 1);
    enable = 1'b0;
    step();
    chk("rst_idle", int'(busy), 0);

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i].s, tbl[i].c, tbl[i].d, $sformatf("vec%0d", i));

    // Bouncing sensor never settles
    enable = 1'b1;
    sensor = 5'b01000;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cmd_valid !== 1'b0) ok = 1'b0;
      if (i % 2 == 1) sensor = sensor ^ 5'b01000;
    end
    chk("bounce_no_valid", int'(ok), 1);
    expq.push_back(2'b00);
    wait_valid("bounce_lat");
    finish_cmd("bounce", 0);

    // Backpressure with enable dropped and sensor changed
    sensor    = 5'b10000;
    enable    = 1'b1;
    cmd_ready = 1'b0;
    wait_valid("bp_lat");
    enable = 1'b0;
    sensor = 5'b01110;
    h0 = hs;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cmd_valid !== 1'b1 || cmd !== 2'b10) ok = 1'b0;
    end
    chk("bp_hold", int'(ok), 1);
    expq.push_back(2'b10);
    cmd_ready = 1'b1;
    finish_cmd("bp", 8);
    chk("bp_single_hs", hs - h0, 1);
    step();
    chk("bp_idle", int'(busy), 0);

    // Sensor change on the fifth EXEC edge of a FWD command
    sensor    = 5'b11111;
    enable    = 1'b1;
    cmd_ready = 1'b1;
    expq.push_back(2'b01);
    wait_valid("ab_lat");
    step();
    enable = 1'b0;
    for (int e = 1; e < 5; e++) step();
    sensor = 5'b00000;
    step();
`ifdef STEER_SAFE_ABORT_EN
    chk("ab_pulse_hi", int'(abort_pulse), 1);
    chk("ab_settle_busy", int'(busy), 1);
    chk("ab_walk_count", int'(walk_count), wc_m);
    step();
    chk("ab_pulse_lo", int'(abort_pulse), 0);
    chk("ab_idle", int'(busy), 0);
`else
    begin
      int k = 5;
      while (busy === 1'b1 && k < 100) begin
        step();
        k++;
      end
      chk("noab_dur", k, 16);
      if (wc_m < 3) wc_m++;
      chk("noab_walk_count", int'(walk_count), wc_m);
    end
`endif

    for (int i = 0; i < 3; i++)
      run_vec(5'b11111, 2'b01, 16, $sformatf("sat%0d", i));
    chk("sat_final", int'(walk_count), 3);

    // Asynchronous reset withdraws an offered command
    sensor    = 5'b10000;
    enable    = 1'b1;
    cmd_ready = 1'b0;
    wait_valid("arst_lat");
    reset_n = 1'b0;
    #1;
    chk("arst_valid", int'(cmd_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_walk_count", int'(walk_count), 0);
    chk("sb_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/steer_sequencer.md
Name: steer_sequencer

Overview:
- Sequencer for the combinational steering decoder, which turns 5 sensor bits into left/right/walk decisions.
- Debounces the sensor vector, samples the decoder's decision once the vector is stable, and issues one motor command over a valid/ready handshake.
- Holds that command for a fixed duration, then re-arms.
- Sits between the sensor front end plus steering decoder and the motor driver.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical sensor samples required before a decision (min 1).
- TURN_CYCLES, 8, execution cycles for LEFT/RIGHT commands (min 1).
- WALK_CYCLES, 16, execution cycles for FWD commands (min 1).
- CNT_W, 8, width of walk_count.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- sensor  in  5  raw sensor vector; the same vector also drives the steering decoder.
- steer_left  in  1  decoder left output.
- steer_right  in  1  decoder right output.
- steer_walk  in  1  decoder walk output.
- cmd_valid  out  1  command offered to motor driver.
- cmd_ready  in  1  motor driver accepts.
- cmd  out  2  command code: 00 STOP, 01 FWD, 10 LEFT, 11 RIGHT.
- busy  out  1  high in any state other than IDLE.
- walk_count  out  CNT_W  completed FWD commands; saturates at all-ones.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset values: state=IDLE, cmd_valid=0, cmd=00, busy=0, walk_count=0, internal counters and latches 0. Reset asserted mid-operation aborts immediately; any offered command is withdrawn with no handshake.
- Decision map, evaluated on steer_* at the sampling edge:
  - walk=1 -> FWD
  - else left=1 and right=0 -> LEFT
  - else right=1 and left=0 -> RIGHT
  - else -> STOP
- IDLE:
  - enable=1: latch sensor into s_q, set settle count to 1, go to SETTLE.
  - enable=0: stay in IDLE.
- SETTLE:
  - enable=0: go to IDLE.
  - sensor!=s_q: reload s_q, set count to 1.
  - otherwise increment count.
  - The edge at which count reaches SETTLE_CYCLES latches the decision into cmd_q and goes to ISSUE.
  - With SETTLE_CYCLES=1, IDLE goes directly to ISSUE and samples the decision at the same edge.
- Latency: stable sensor with enable high produces cmd_valid=1 after exactly SETTLE_CYCLES rising edges, counted from the IDLE capture edge.
- ISSUE:
  - cmd_valid=1 and cmd=cmd_q.
  - cmd is stable until the handshake; valid is never withdrawn, even if enable falls or sensor changes.
  - Handshake occurs on an edge with cmd_valid and cmd_ready both high. cmd_valid drops on the following cycle.
  - After handshake: STOP goes to IDLE. LEFT/RIGHT load a duration of TURN_CYCLES and go to EXEC. FWD loads WALK_CYCLES and goes to EXEC.
- EXEC:
  - cmd_valid=0; duration decrements each edge.
  - The edge on which the duration reaches 0 ends the command. FWD increments walk_count, saturating. Next state is SETTLE (fresh capture of sensor, count 1) if enable=1, else IDLE.
  - enable falling during EXEC does not shorten the command.
- cmd holds its last value outside ISSUE. Only cmd_valid qualifies it.

Optional Feature:
- Macro: STEER_SAFE_ABORT_EN.
- Defined:
  - During EXEC of FWD, sensor!=s_q on any edge aborts the command.
  - Next state is SETTLE with the new sensor captured (count 1). walk_count is not incremented.
  - Adds output port abort_pulse (1 bit), high for exactly one cycle after the aborting edge; reset value 0.
- Undefined: there is no abort_pulse port, and EXEC always runs the full duration.

Decomposition:
- Package steer_pkg holds:
  - Command enum: STOP=2'b00, FWD=2'b01, LEFT=2'b10, RIGHT=2'b11.
  - FSM state enum: IDLE, SETTLE, ISSUE, EXEC.
  - The decision-map function (steer_* to command).
- One sub-module, steer_debounce, owns s_q and the settle counter. Inputs: sensor, start, clear. Output: stable pulse.
- The top module holds the FSM, the duration counter and walk_count.

Test Plan:
- Reset behaviour: reset_n low for 3 cycles with enable=1 -> all outputs 0. Release with sensor=5'b00000 stable (decoder left=0, right=0, walk=0) and cmd_ready=1 -> cmd_valid after 4 edges with cmd=STOP; FSM back to IDLE, then SETTLE since enable=1; walk_count=0.
- Walk command: sensor=5'b01110 stable (walk=0, right=1) -> RIGHT. Then sensor=5'b11111 (walk=1) -> FWD issued, 16 EXEC cycles, walk_count=1.
- Bounce: sensor toggles 5'b01000/5'b00000 every 2 cycles for 20 cycles -> cmd_valid stays 0. Sensor then stable at 5'b01000 -> cmd_valid after 4 edges.
- Backpressure: cmd_ready=0 for 10 cycles while in ISSUE, with enable dropped and sensor changed -> cmd_valid and cmd held constant. cmd_ready=1 -> single handshake, then EXEC runs the full duration, then IDLE.
- Saturation: CNT_W=2, five FWD commands -> walk_count reaches 3 and stays at 3.
- Abort with STEER_SAFE_ABORT_EN defined: sensor changes on EXEC cycle 5 of FWD -> abort_pulse high for 1 cycle, walk_count unchanged, state=SETTLE. Same stimulus with the macro undefined -> full 16 cycles and walk_count increments.
